// File: rtl/axis_pkg.sv
// Shared types for the packet-aware AXI-stream demux: input FSM encoding and skid FIFO entry.
package axis_pkg;

    localparam int DW = 512;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          dest;
    } entry_t;

endpackage

// File: rtl/packet_axis_demux_if.sv
// AXI-stream bundle: master drives data/last/valid, slave drives ready.
interface packet_axis_if #(parameter int DW = axis_pkg::DW);

    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tvalid;
    logic          tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);

endinterface

// File: rtl/axis_skid_fifo2.sv
// Two-entry registered FIFO with registered not-full (wr_rdy) and empty flags.
// Latency: a word written at edge N is readable from edge N onward.
// Backpressure: wr_rdy drops when two words are held, rises the cycle after a pop.
module axis_skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         wr_rdy,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat,
    input  logic         rd_rdy
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic [1:0]   cnt_nxt;
    logic         empty_q;
    logic         push;
    logic         pop;

    assign push    = wr_vld && wr_rdy;
    assign pop     = rd_rdy && !empty_q;
    assign cnt_nxt = cnt + 2'(push) - 2'(pop);
    assign rd_vld  = !empty_q;
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            empty_q <= 1'b1;
            wr_rdy  <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            empty_q <= (cnt_nxt == 2'd0);
            wr_rdy  <= (cnt_nxt != 2'd2);
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end

    // Storage is pure datapath; validity is tracked by cnt/empty_q alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/packet_axis_demux.sv
// Packet-aware 1:2 AXI-stream demux; destination latched on first beat, held to tlast.
// Latency: a beat accepted at edge N is presented on its output in cycle N+1.
// Backpressure: 2-entry skid absorbs destination stalls; input ready is registered not-full.
module packet_axis_demux
    import axis_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          output_select,
    packet_axis_if.slave  axis_in,
    packet_axis_if.master axis0,
    packet_axis_if.master axis1,
    output logic [CW-1:0] pkt_count0,
    output logic [CW-1:0] pkt_count1,
    output logic          busy
);

    state_t state;
    state_t state_nxt;
    logic   route_q;
    logic   beat_dest;
    logic   accept;
    logic   in_rdy;
    entry_t wr_entry;
    entry_t head;
    logic   head_vld;
    logic   head_rdy;

    assign accept         = axis_in.tvalid && in_rdy;
    assign axis_in.tready = in_rdy;

    always_comb begin
        state_nxt = state;
        beat_dest = route_q;
        busy      = (state == IN_PKT);
        case (state)
            IDLE: begin
                beat_dest = output_select;
                if (accept && !axis_in.tlast) state_nxt = IN_PKT;
            end
            IN_PKT: begin
                if (accept && axis_in.tlast) state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            route_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept) route_q <= output_select;
        end
    end

    assign wr_entry = '{data: axis_in.tdata, last: axis_in.tlast, dest: beat_dest};

    axis_skid_fifo2 #(.W($bits(entry_t))) u_skid (
        .clk    (clk),
        .rst_n  (resetn),
        .wr_vld (axis_in.tvalid),
        .wr_dat (wr_entry),
        .wr_rdy (in_rdy),
        .rd_vld (head_vld),
        .rd_dat (head),
        .rd_rdy (head_rdy)
    );

    // The idle output's ready must never pop the head.
    assign head_rdy     = head.dest ? axis1.tready : axis0.tready;

    assign axis0.tvalid = head_vld && !head.dest;
    assign axis0.tdata  = head.data;
    assign axis0.tlast  = head.last;
    assign axis1.tvalid = head_vld && head.dest;
    assign axis1.tdata  = head.data;
    assign axis1.tlast  = head.last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pkt_count0 <= '0;
            pkt_count1 <= '0;
        end else begin
            if (axis0.tvalid && axis0.tready && head.last) pkt_count0 <= pkt_count0 + 1'b1;
            if (axis1.tvalid && axis1.tready && head.last) pkt_count1 <= pkt_count1 + 1'b1;
        end
    end

endmodule

// File: tb/tb_packet_axis_demux.sv
// Directed bench for packet_axis_demux with a per-output scoreboard of expected beats.
module tb_packet_axis_demux;
    import axis_pkg::*;

    logic clk;
    logic resetn;
    logic osel;
    logic wsel;
    logic [31:0] cnt0, cnt1;
    logic [3:0]  w_cnt0, w_cnt1;
    logic busy, w_busy;

    packet_axis_if in_if ();
    packet_axis_if o0 ();
    packet_axis_if o1 ();
    packet_axis_if w_in ();
    packet_axis_if w0 ();
    packet_axis_if w1 ();

    packet_axis_demux #(.CW(32)) dut (
        .clk(clk), .resetn(resetn), .output_select(osel),
        .axis_in(in_if), .axis0(o0), .axis1(o1),
        .pkt_count0(cnt0), .pkt_count1(cnt1), .busy(busy)
    );

    packet_axis_demux #(.CW(4)) wdut (
        .clk(clk), .resetn(resetn), .output_select(wsel),
        .axis_in(w_in), .axis0(w0), .axis1(w1),
        .pkt_count0(w_cnt0), .pkt_count1(w_cnt1), .busy(w_busy)
    );

    int checks = 0;
    int errors = 0;
    int busy_cycles = 0;
    logic [DW:0] q0 [$];
    logic [DW:0] q1 [$];
    logic m_in_pkt = 1'b0;
    logic m_route = 1'b0;
    int exp0 = 0;
    int exp1 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int n);
        logic [31:0] w;
        w = 32'hA500_0000 ^ 32'(n);
        return {16{w}};
    endfunction

    // Scoreboard monitors: every transfer must match the head of that output's queue.
    always @(negedge clk) begin
        logic [DW:0] e;
        if (resetn && o0.tvalid && o0.tready) begin
            if (q0.size() == 0) chk("o0_unexpected_beat", o0.tvalid, 1'b0);
            else begin
                e = q0.pop_front();
                chk("o0_data", o0.tdata, e[DW-1:0]);
                chk("o0_last", o0.tlast, e[DW]);
            end
        end
        if (resetn && o1.tvalid && o1.tready) begin
            if (q1.size() == 0) chk("o1_unexpected_beat", o1.tvalid, 1'b0);
            else begin
                e = q1.pop_front();
                chk("o1_data", o1.tdata, e[DW-1:0]);
                chk("o1_last", o1.tlast, e[DW]);
            end
        end
        if (busy) busy_cycles++;
    end

    task automatic send(input int n, input logic last, input logic sel);
        int w;
        logic dest;
        in_if.tdata  = mk(n);
        in_if.tlast  = last;
        in_if.tvalid = 1'b1;
        osel         = sel;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!in_if.tready && w < 64);
        if (!in_if.tready) chk("accept_timeout", in_if.tready, 1'b1);
        else begin
            dest = m_in_pkt ? m_route : sel;
            if (!m_in_pkt) m_route = sel;
            m_in_pkt = !last;
            if (dest) begin q1.push_back({last, mk(n)}); if (last) exp1++; end
            else      begin q0.push_back({last, mk(n)}); if (last) exp0++; end
        end
        @(posedge clk);
        #1;
        in_if.tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 513'(q0.size() + q1.size()), '0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        resetn = 1'b0;
        osel = 1'b0;
        wsel = 1'b0;
        in_if.tvalid = 1'b0; in_if.tlast = 1'b0; in_if.tdata = '0;
        w_in.tvalid = 1'b0;  w_in.tlast = 1'b0;  w_in.tdata = '0;
        o0.tready = 1'b1; o1.tready = 1'b1;
        w0.tready = 1'b1; w1.tready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_tready", in_if.tready, 1'b0);
        chk("rst_o0_tvalid", o0.tvalid, 1'b0);
        chk("rst_o1_tvalid", o1.tvalid, 1'b0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", in_if.tready, 1'b1);

        // 4-beat packet to axis0, one-cycle latency, busy for 3 cycles
        busy_cycles = 0;
        send(10, 1'b0, 1'b0);
        chk("lat_o0_tvalid", o0.tvalid, 1'b1);
        chk("lat_o0_tdata", o0.tdata, mk(10));
        chk("lat_o1_tvalid", o1.tvalid, 1'b0);
        chk("busy_in_pkt", busy, 1'b1);
        send(11, 1'b0, 1'b0);
        send(12, 1'b0, 1'b0);
        send(13, 1'b1, 1'b0);
        drain();
        chk("t1_busy_cycles", busy_cycles, 3);
        chk("t1_cnt0", cnt0, exp0);
        chk("t1_cnt1", cnt1, 0);

        // Select toggled mid-packet: ignored until next packet start
        send(20, 1'b0, 1'b0);
        send(21, 1'b0, 1'b1);
        send(22, 1'b1, 1'b1);
        send(23, 1'b0, 1'b1);
        send(24, 1'b1, 1'b0);
        drain();
        chk("t2_cnt0", cnt0, exp0);
        chk("t2_cnt1", cnt1, 1);

        // Back-to-back single-beat packets alternating destination
        busy_cycles = 0;
        send(30, 1'b1, 1'b0);
        send(31, 1'b1, 1'b1);
        send(32, 1'b1, 1'b0);
        send(33, 1'b1, 1'b1);
        drain();
        chk("t3_busy_cycles", busy_cycles, 0);
        chk("t3_cnt0", cnt0, exp0);
        chk("t3_cnt1", cnt1, exp1);

        // axis0 stalls mid-packet: two beats absorbed, then input ready drops
        o0.tready = 1'b0;
        send(40, 1'b0, 1'b0);
        send(41, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_tready", in_if.tready, 1'b0);
            chk("stall_o0_tvalid", o0.tvalid, 1'b1);
            chk("stall_o0_tdata", o0.tdata, mk(40));
            chk("stall_o1_tvalid", o1.tvalid, 1'b0);
        end
        @(posedge clk);
        #1;
        o0.tready = 1'b1;
        @(negedge clk);
        chk("stall_rdy_before_pop", in_if.tready, 1'b0);
        @(posedge clk);
        #1;
        chk("stall_rdy_after_pop", in_if.tready, 1'b1);
        send(42, 1'b0, 1'b1);
        send(43, 1'b1, 1'b1);
        drain();
        chk("t4_cnt0", cnt0, exp0);
        chk("t4_cnt1", cnt1, exp1);

        // Reset mid-packet flushes buffered beats
        o0.tready = 1'b0;
        send(50, 1'b0, 1'b0);
        send(51, 1'b0, 1'b0);
        resetn = 1'b0;
        q0.delete();
        q1.delete();
        m_in_pkt = 1'b0;
        exp0 = 0;
        exp1 = 0;
        #1;
        chk("mid_rst_o0_tvalid", o0.tvalid, 1'b0);
        chk("mid_rst_o1_tvalid", o1.tvalid, 1'b0);
        chk("mid_rst_cnt0", cnt0, 0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_tready", in_if.tready, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        o0.tready = 1'b1;
        send(60, 1'b0, 1'b1);
        send(61, 1'b1, 1'b0);
        drain();
        chk("t5_cnt0", cnt0, 0);
        chk("t5_cnt1", cnt1, 1);

        // 4-bit counter wraps: 17 single-beat packets leave count 1
        w_in.tlast = 1'b1;
        for (int i = 0; i < 17; i++) begin
            w_in.tdata = mk(100 + i);
            w_in.tvalid = 1'b1;
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!w_in.tready && w < 64);
            if (!w_in.tready) chk("wrap_accept_timeout", w_in.tready, 1'b1);
            @(posedge clk);
            #1;
            w_in.tvalid = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("wrap_cnt0", w_cnt0, 4'd1);
        chk("wrap_cnt1", w_cnt1, 4'd0);
        chk("wrap_o1_tvalid", w1.tvalid, 1'b0);
        chk("wrap_o0_idle", w0.tvalid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
